// File: rtl/rv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset controller:
// FSM states, opcodes, ALU function codes, mux select codes and the
// per-state Moore control word.
package rv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALR2    = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13,
        S_FAULT    = 4'd14
    } state_t;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU function codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b110;

    // R-type funct7 for sub
    localparam logic [6:0] F7_ALT = 7'b0100000;

    // Class of ALU operation the FSM asks for; the decoder refines R/I
    typedef enum logic [1:0] {
        AOP_ADD = 2'b00,
        AOP_SUB = 2'b01,
        AOP_R   = 2'b10,
        AOP_I   = 2'b11
    } alu_op_t;

    // Source selects
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] RES_IMM     = 2'b11;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_J = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // Moore part of the control outputs; input-gated strobes are added in the top
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       pc_write;
        logic       reg_write;
        logic       retire;
        logic       fault;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        alu_op_t    alu_op;
    } ctrl_t;

    // Control word held while the FSM sits in state s
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b0;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_MEM;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = AOP_R;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = AOP_I;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_JAL, S_JALR2: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = AOP_SUB;
                c.result_src = RES_ALUOUT;
                c.retire     = 1'b1;
            end
            S_LUI: begin
                c.result_src = RES_IMM;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_FAULT: begin
                c.fault = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Immediate format implied by the opcode
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] r;
        case (op)
            OP_STORE:  r = IMM_S;
            OP_JAL:    r = IMM_J;
            OP_BRANCH: r = IMM_B;
            OP_LUI:    r = IMM_U;
            default:   r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU function decode: combines the FSM's operation class with the
// instruction funct fields. Unknown funct codes fall back to add.
module alu_decoder
    import rv_mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] alu_func
);

    // Map operation class and funct fields to an ALU function code
    always_comb begin
        alu_func = ALU_ADD;
        case (alu_op)
            AOP_ADD: alu_func = ALU_ADD;
            AOP_SUB: alu_func = ALU_SUB;
            AOP_R: begin
                case (funct3)
                    3'b000:  alu_func = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_func = ALU_AND;
                    3'b110:  alu_func = ALU_OR;
                    3'b010:  alu_func = ALU_SLT;
                    default: alu_func = ALU_ADD;
                endcase
            end
            AOP_I: begin
                case (funct3)
                    3'b000:  alu_func = ALU_ADD;
                    3'b100:  alu_func = ALU_XOR;
                    3'b110:  alu_func = ALU_OR;
                    3'b010:  alu_func = ALU_SLT;
                    default: alu_func = ALU_ADD;
                endcase
            end
            default: alu_func = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I-subset control unit. One FSM walks each instruction
// through fetch/decode/execute/writeback over a shared memory port.
// Handshake: a memory access is in progress whenever mem_req=1; the access
// completes in the cycle where mem_ready=1, and the FSM advances on that
// edge. mem_ready is ignored while mem_req=0. A watchdog faults the unit
// when an access waits MEM_TIMEOUT cycles without mem_ready.
module multicycle_controller
    import rv_mc_pkg::*;
#(
    parameter int BRANCH_EXT  = 1,
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        neg,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic [2:0]  alu_func,
    output logic        retire,
    output logic        fault
);

    state_t           state;
    state_t           state_nxt;
    ctrl_t            ctrl;
    logic [TMO_W-1:0] wdog;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       wait_state;
    logic       waiting;
    logic       timeout;
    logic       taken;
    logic       fetch_go;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    // States that sit on the memory port until mem_ready
    assign wait_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign waiting    = wait_state && !mem_ready;
    assign timeout    = (MEM_TIMEOUT > 0) && waiting &&
                        (wdog == TMO_W'(MEM_TIMEOUT - 1));

    // Branch condition from ALU flags (rs1 - rs2)
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = (BRANCH_EXT != 0) && neg;
            F3_BGE:  taken = (BRANCH_EXT != 0) && !neg;
            default: taken = 1'b0;
        endcase
    end

    // Next-state selection; watchdog expiry overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_R:              state_nxt = S_EXEC_R;
                    OP_I:              state_nxt = S_EXEC_I;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_LUI:            state_nxt = S_LUI;
                    default:           state_nxt = S_FAULT;
                endcase
            end
            S_MEMADR:   state_nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
            S_MEMWB:    state_nxt = S_FETCH;
            S_EXEC_R:   state_nxt = S_ALUWB;
            S_EXEC_I:   state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_JALR:     state_nxt = S_JALR2;
            S_JALR2:    state_nxt = S_ALUWB;
            S_BRANCH:   state_nxt = S_FETCH;
            S_LUI:      state_nxt = S_FETCH;
            S_FAULT:    state_nxt = S_FAULT;
            default:    state_nxt = S_FAULT;
        endcase
        if (timeout) begin
            state_nxt = S_FAULT;
        end
    end

    // State, registered control word and watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            ctrl  <= state_ctrl(S_FETCH);
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            ctrl  <= state_ctrl(state_nxt);
            if (state_nxt != state) begin
                wdog <= '0;
            end else if (waiting && (MEM_TIMEOUT > 0)) begin
                wdog <= wdog + 1'b1;
            end
        end
    end

    // Strobes that depend on this cycle's inputs; forced low while reset is held
    assign fetch_go = rst_n && (state == S_FETCH) && mem_ready;

    assign ir_write   = fetch_go;
    assign pc_write   = rst_n && (ctrl.pc_write || fetch_go || ((state == S_BRANCH) && taken));
    assign retire     = rst_n && (ctrl.retire || ((state == S_MEMWRITE) && mem_ready));
    assign mem_req    = ctrl.mem_req;
    assign mem_write  = ctrl.mem_write;
    assign adr_src    = ctrl.adr_src;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign result_src = ctrl.result_src;
    assign fault      = ctrl.fault;
    assign imm_src    = imm_src_of(opcode);

    alu_decoder u_alu_decoder (
        .alu_op   (ctrl.alu_op),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_func (alu_func)
    );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised multi-cycle RV32I-subset control unit; the next generation of the single-cycle controller.
- Sequences each instruction through an FSM over a shared memory port and a single ALU.
- Adds a memory ready/request handshake, optional blt/bge, an illegal-opcode/timeout fault state and a retire pulse.
- Sits between the instruction register / ALU flags and the multi-cycle datapath muxes.

Parameters:
BRANCH_EXT, 1, 1 = blt/bge (f3 100/101) decoded via neg flag; 0 = those f3 codes never taken
MEM_TIMEOUT, 0, max consecutive wait cycles on a memory access before fault; 0 = watchdog disabled
TMO_W, $clog2(MEM_TIMEOUT+1) (min 1), watchdog counter width (derived, do not override)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction register contents (stable after ir_write)
zero  in  1  ALU result == 0
neg  in  1  ALU result sign bit (signed rs1-rs2 < 0)
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_write  out  1  store when mem_req=1
adr_src  out  1  0 = PC, 1 = ALUOut
ir_write  out  1  load IR
pc_write  out  1  load PC from result bus
reg_write  out  1  register file write
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result, 11 imm
imm_src  out  3  000 I, 001 S, 010 J, 011 B, 100 U
alu_func  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 110 xor
retire  out  1  one-cycle pulse when an instruction completes
fault  out  1  high while in FAULT

Behaviour:
- Async reset: state=FETCH, watchdog=0. All outputs take FETCH values with ir_write=pc_write=0.
- Outputs are Moore decodes of state. Exceptions: ir_write and pc_write in FETCH are gated by mem_ready; pc_write in BRANCH is gated by taken.
- Unlisted outputs are 0. alu_func=add unless stated. imm_src always decoded from opcode.
- FETCH: mem_req, adr_src=0, a=00, b=10, result_src=10. When mem_ready: ir_write=pc_write=1, next DECODE. Otherwise hold.
- DECODE: a=01, b=01 (branch/jal target into ALUOut). Next by opcode:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 1100011 -> BRANCH
  - 0110111 -> LUI
  - other -> FAULT
- MEMADR: a=10, b=01. Next MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req, adr_src=1. mem_ready -> MEMWB.
- MEMWB: result_src=01, reg_write, retire -> FETCH.
- MEMWRITE: mem_req, mem_write, adr_src=1. mem_ready -> FETCH with retire in that cycle.
- EXEC_R: a=10, b=00, alu_func per R decode (f7/f3: add, sub 0100000/000, and 111, or 110, slt 010) -> ALUWB.
- EXEC_I: a=10, b=01, alu_func per I decode (000 add, 100 xor, 110 or, 010 slt) -> ALUWB.
- ALUWB: result_src=00, reg_write, retire -> FETCH.
- JAL: a=01, b=10, result_src=00, pc_write -> ALUWB (writes oldPC+4).
- JALR: a=10, b=01 -> JALR2.
- JALR2: a=01, b=10, result_src=00, pc_write -> ALUWB.
- BRANCH: a=10, b=00, sub, result_src=00, retire -> FETCH. taken =
  - beq: zero
  - bne: !zero
  - blt: neg (BRANCH_EXT only)
  - bge: !neg (BRANCH_EXT only)
  - other f3: 0
- LUI: result_src=11, reg_write, retire -> FETCH.
- Unknown R/I funct codes: alu_func=add, no fault.
- Watchdog (MEM_TIMEOUT>0):
  - counts consecutive cycles in FETCH/MEMREAD/MEMWRITE with mem_ready=0; cleared on state change.
  - On the edge ending the MEM_TIMEOUT-th waiting cycle -> FAULT.
  - mem_ready in the same cycle wins over timeout.
- FAULT: fault=1, mem_req=0, no writes. Sticky until rst_n low.
- Reset mid-instruction: aborts immediately. No partial write occurs after reset assertion.

Decomposition:
- Package rv_mc_pkg: state enum, opcode localparams, alu_func codes, src-select codes, f3 branch codes.
- Sub-module alu_decoder (combinational: alu op class, f3, f7 -> alu_func) instantiated once.
- FSM, watchdog and branch logic stay in the top.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH, DECODE, EXEC_R (alu_func=000), ALUWB (reg_write=1, retire=1): 4 cycles.
- lw x5,8(x0) (0x00802283), mem_ready low 2 cycles in MEMREAD -> mem_req=1 adr_src=1 held 3 cycles, then MEMWB reg_write=1 result_src=01.
- beq (0x00208463): zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; both retire=1.
- blt (0x0020C463), neg=1 -> pc_write=1 with BRANCH_EXT=1; pc_write=0 with BRANCH_EXT=0.
- instr=0x0000007F -> FAULT after DECODE, fault=1, mem_req=0 for 20 cycles; rst_n pulse -> FETCH, fault=0.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 cycles; repeat with mem_ready=1 on 4th cycle -> DECODE, no fault.
